// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - boot-time byte-stream to 32-bit instruction ROM writer
module rom_loader #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH_WORDS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_idx;
    logic [31:0]         r_word;
    logic                r_last;
    logic [ADDR_W:0]     r_word_count;
    logic [ADDR_W-1:0]   r_wr_addr;

    logic                w_accept;
    logic                w_word_end;
    logic                w_start_ok;
    logic [ADDR_W:0]     w_cnt_inc;

    assign w_accept   = (r_state == S_RECV) && byte_valid;
    assign w_word_end = w_accept && ((r_idx == 2'd3) || byte_last);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE)
                                  || (r_state == S_ERR));
    assign w_cnt_inc  = r_word_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (w_word_end) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                // The final word wins over the limit, so an exact-fit image ends in DONE.
                if (r_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_cnt_inc == DEPTH_CNT) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= 2'd0;
            r_word       <= 32'd0;
            r_last       <= 1'b0;
            r_word_count <= '0;
            r_wr_addr    <= '0;
        end else if (w_start_ok) begin
            r_idx        <= 2'd0;
            r_word       <= 32'd0;
            r_last       <= 1'b0;
            r_word_count <= '0;
            r_wr_addr    <= '0;
        end else if (r_state == S_RECV) begin
            if (w_accept) begin
                r_word[{r_idx, 3'b000} +: 8] <= byte_data;
                r_idx                        <= r_idx + 2'd1;
                r_last                       <= byte_last;
            end
            // Latch the address only for a real write so it never wraps after overflow.
            if (w_word_end) begin
                r_wr_addr <= r_word_count[ADDR_W-1:0];
            end
        end else if (r_state == S_WRITE) begin
            r_word_count <= w_cnt_inc;
            r_idx        <= 2'd0;
            r_word       <= 32'd0;
            r_last       <= 1'b0;
        end
    end

    assign byte_ready = (r_state == S_RECV);
    assign wr_en      = (r_state == S_WRITE);
    assign wr_addr    = r_wr_addr;
    assign wr_data    = wr_en ? r_word : 32'd0;
    assign word_count = r_word_count;
    assign busy       = (r_state == S_RECV) || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    // Core is released only while DONE; a restart pulls it back in the same cycle.
    assign cpu_rst_n  = (r_state == S_DONE) && !start;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed self-checking bench for rom_loader
module tb_rom_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_last;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_rst_n;

    rom_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_rst_n  (cpu_rst_n)
    );

    int n_vectors = 0;
    int n_miscompares = 0;
    int cyc = 0;
    int n_acc = 0;
    int tb_idx = 0;
    logic [31:0] q_wdata[$];
    int          q_waddr[$];
    int          q_wcyc[$];
    int          q_ccyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            tb_idx = 0;
        end else begin
            if (byte_valid && byte_ready) begin
                n_acc++;
                if (tb_idx == 3 || byte_last) begin
                    q_ccyc.push_back(cyc);
                    tb_idx = 0;
                end else begin
                    tb_idx++;
                end
            end
            if (wr_en) begin
                q_wdata.push_back(wr_data);
                q_waddr.push_back(int'(wr_addr));
                q_wcyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q_wdata.delete();
        q_waddr.delete();
        q_wcyc.delete();
        q_ccyc.delete();
        n_acc  = 0;
        tb_idx = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_write(input string tag, input int k, input int addr, input logic [31:0] data);
        if (q_wdata.size() > k) begin
            chk({tag, "_addr"}, q_waddr[k], addr);
            chk({tag, "_data"}, q_wdata[k], data);
        end else begin
            chk({tag, "_missing"}, q_wdata.size(), k + 1);
        end
    endtask

    logic [7:0] t1_bytes[8];
    logic [7:0] t2_bytes[5];

    initial begin
        t1_bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        t2_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_flags", {busy, done, error}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1 basic load
        clear_mon();
        pulse_start();
        for (int i = 0; i < 8; i++) send(t1_bytes[i], i == 7, 0);
        wait_done("t1_done");
        chk("t1_nwr", q_wdata.size(), 2);
        check_write("t1_w0", 0, 0, 32'h0000_0013);
        check_write("t1_w1", 1, 1, 32'h0010_0093);
        chk("t1_cpu_rst_n", cpu_rst_n, 1);
        chk("t1_word_count", word_count, 2);
        chk("t1_error", error, 0);

        // T2 partial word
        clear_mon();
        pulse_start();
        for (int i = 0; i < 5; i++) send(t2_bytes[i], i == 4, 0);
        wait_done("t2_done");
        chk("t2_nwr", q_wdata.size(), 2);
        check_write("t2_w0", 0, 0, 32'h0403_0201);
        check_write("t2_w1", 1, 1, 32'h0000_00AA);

        // T3 overflow
        clear_mon();
        pulse_start();
        for (int i = 0; i < 16; i++) send(8'h11, 1'b0, 0);
        byte_valid = 1'b1; byte_data = 8'h11;
        repeat (10) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        @(negedge clk);
        chk("t3_error", error, 1);
        chk("t3_byte_ready", byte_ready, 0);
        chk("t3_nacc", n_acc, 16);
        chk("t3_nwr", q_wdata.size(), 4);
        for (int k = 0; k < 4; k++) check_write("t3_w", k, k, 32'h1111_1111);
        chk("t3_done", done, 0);
        chk("t3_cpu_rst_n", cpu_rst_n, 0);
        chk("t3_wr_addr_nowrap", wr_addr, 3);

        // T4 exact fit, started from ERR
        clear_mon();
        pulse_start();
        chk("t4_error_cleared", error, 0);
        for (int i = 0; i < 16; i++) send(8'(i + 1), i == 15, 0);
        wait_done("t4_done");
        chk("t4_error", error, 0);
        chk("t4_nwr", q_wdata.size(), 4);
        check_write("t4_w0", 0, 0, 32'h0403_0201);
        check_write("t4_w3", 3, 3, 32'h100F_0E0D);
        chk("t4_word_count", word_count, 4);

        // T5 backpressure, with an ignored start mid-load
        clear_mon();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send(t1_bytes[i], i == 7, i % 4);
            if (i == 2) pulse_start();
        end
        wait_done("t5_done");
        chk("t5_nwr", q_wdata.size(), 2);
        check_write("t5_w0", 0, 0, 32'h0000_0013);
        check_write("t5_w1", 1, 1, 32'h0010_0093);
        for (int k = 0; k < 2; k++) begin
            if (q_wcyc.size() > k && q_ccyc.size() > k)
                chk("t5_wr_latency", q_wcyc[k] - q_ccyc[k], 1);
            else
                chk("t5_latency_missing", q_wcyc.size(), 2);
        end

        // T6 reset mid-load then reload
        clear_mon();
        pulse_start();
        for (int i = 0; i < 3; i++) send(t1_bytes[i], 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", {busy, done, error, byte_ready, wr_en, cpu_rst_n}, 0);
        chk("t6_rst_word_count", word_count, 0);
        chk("t6_rst_wr_data", wr_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 5; i++) send(t2_bytes[i], i == 4, 0);
        wait_done("t6_done");
        chk("t6_nwr", q_wdata.size(), 2);
        check_write("t6_w0", 0, 0, 32'h0403_0201);
        check_write("t6_w1", 1, 1, 32'h0000_00AA);
        @(posedge clk); #1;
        chk("t6_cpu_rst_n_pre", cpu_rst_n, 1);
        start = 1'b1;
        #1;
        chk("t6_cpu_rst_n_same_cycle", cpu_rst_n, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("t6_restart_busy", busy, 1);
        chk("t6_restart_word_count", word_count, 0);
        chk("t6_restart_cpu_rst_n", cpu_rst_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
